// File: rtl/mac_pkg.sv
// mac_pkg: shared width and saturation helpers for the mac_array_acc datapath.
//   prod_w(bw)        - width of one signed lane product, unsigned(bw) x signed(bw)
//   sum_w(bw, lanes)  - width of the signed sum of all lane products
//   sat_hi/sat_lo(w)  - two's-complement limits of a w-bit signed value
package mac_pkg;

  function automatic int prod_w(input int bw);
    return 2 * bw + 1;
  endfunction

  function automatic int sum_w(input int bw, input int lanes);
    return prod_w(bw) + $clog2(lanes);
  endfunction

  function automatic longint sat_hi(input int psum_bw);
    return (longint'(1) <<< (psum_bw - 1)) - longint'(1);
  endfunction

  function automatic longint sat_lo(input int psum_bw);
    return -(longint'(1) <<< (psum_bw - 1));
  endfunction

endpackage

// File: rtl/mac_lane.sv
// mac_lane: one multiplier lane, zero-extended unsigned activation times
// sign-extended signed weight.
//   a    - unsigned activation, bw bits
//   b    - two's-complement weight, bw bits
//   prod - signed product, 2*bw+1 bits (always fits, no truncation loss)
module mac_lane
  import mac_pkg::*;
#(
  parameter int bw = 4
) (
  input  logic [bw-1:0]                a,
  input  logic [bw-1:0]                b,
  output logic signed [prod_w(bw)-1:0] prod
);

  localparam int pw = prod_w(bw);

  logic signed [pw-1:0] a_ext;
  logic signed [pw-1:0] b_ext;

  assign a_ext = {{(pw - bw){1'b0}}, a};
  assign b_ext = {{(pw - bw){b[bw-1]}}, b};
  assign prod  = a_ext * b_ext;

endmodule

// File: rtl/mac_array_acc.sv
// mac_array_acc: pipelined multi-lane multiply-accumulate unit.
// Each accepted beat forms the dot product of `lanes` unsigned activations and
// signed weights (stage S1), then adds it into a group accumulator (stage S2).
// The first beat of a group may seed the accumulator from c_in. One result is
// emitted per group through a valid/ready handshake.
// Ports:
//   clk, reset_n       - clock, synchronous active-low reset
//   in_valid/in_ready  - input beat handshake (in_ready = !stall)
//   in_last            - beat closes its accumulation group
//   a, b               - packed activations (unsigned) / weights (signed), lane i at [i*bw +: bw]
//   c_load, c_in       - seed the accumulator with c_in on a group's first beat
//   out/out_valid/out_ready - result handshake
// Build option: define MAC_SAT_EN to saturate the accumulation instead of wrapping.
module mac_array_acc
  import mac_pkg::*;
#(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int lanes   = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [lanes*bw-1:0]   a,
  input  logic [lanes*bw-1:0]   b,
  input  logic                  c_load,
  input  logic [psum_bw-1:0]    c_in,
  output logic [psum_bw-1:0]    out,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int pw = prod_w(bw);
  localparam int sw = sum_w(bw, lanes);

  logic stall;
  logic accept;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;

  // ---------------- lane multipliers ----------------
  logic signed [pw-1:0] lane_prod [lanes];

  for (genvar i = 0; i < lanes; i++) begin : g_lane
    mac_lane #(.bw(bw)) u_lane (
      .a    (a[i*bw +: bw]),
      .b    (b[i*bw +: bw]),
      .prod (lane_prod[i])
    );
  end

  // ---------------- stage S1 ----------------
  logic signed [pw-1:0]      s1_prod [lanes];
  logic                      s1_valid;
  logic                      s1_last;
  logic                      s1_c_load;
  logic signed [psum_bw-1:0] s1_c_in;

  // A stalled edge holds S1; otherwise the valid bit follows in_valid, which
  // equals accept whenever the unit is not stalled.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
    end else if (!stall) begin
      s1_valid <= in_valid;
    end
  end

  // NOTE: payload registers carry no reset; s1_valid alone qualifies them, so
  // resetting the wide data path would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_prod   <= lane_prod;
      s1_last   <= in_last;
      s1_c_load <= c_load;
      s1_c_in   <= c_in;
    end
  end

  // ---------------- stage S2: adder tree + accumulate ----------------
  logic signed [sw-1:0]      lane_sum;
  logic signed [psum_bw-1:0] sum_ext;
  logic signed [psum_bw-1:0] base;
  logic signed [psum_bw-1:0] acc;
  logic signed [psum_bw-1:0] result;
  logic                      first;

  // NOTE: blocking assignments here are deliberate: the loop builds the sum
  // sequentially within one evaluation, and the default first prevents latches.
  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < lanes; i++) begin
      lane_sum = lane_sum + sw'(s1_prod[i]);
    end
  end

  assign sum_ext = psum_bw'(lane_sum);
  assign base    = first ? (s1_c_load ? s1_c_in : '0) : acc;

`ifdef MAC_SAT_EN
  localparam logic signed [psum_bw-1:0] sat_max = psum_bw'(sat_hi(psum_bw));
  localparam logic signed [psum_bw-1:0] sat_min = psum_bw'(sat_lo(psum_bw));

  logic signed [psum_bw:0] wide;

  // One guard bit is enough: the top two bits disagree exactly on overflow,
  // and the guard bit gives the true sign.
  assign wide = {base[psum_bw-1], base} + {sum_ext[psum_bw-1], sum_ext};

  always_comb begin
    result = wide[psum_bw-1:0];
    if (wide[psum_bw] != wide[psum_bw-1]) begin
      result = wide[psum_bw] ? sat_min : sat_max;
    end
  end
`else
  assign result = base + sum_ext;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc       <= '0;
      first     <= 1'b1;
      out       <= '0;
      out_valid <= 1'b0;
    end else if (!stall) begin
      if (s1_valid) begin
        acc   <= result;
        first <= s1_last;
        if (s1_last) begin
          out       <= result;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end else begin
        // Not stalled: either nothing was pending or the consumer took it.
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_array_acc.sv
// Directed testbench for mac_array_acc (defaults: lanes=4, bw=4, psum_bw=16).
// Inputs are driven 1 time unit after each rising edge, outputs sampled there.
module tb_mac_array_acc;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [15:0] a;
  logic [15:0] b;
  logic        c_load;
  logic [15:0] c_in;
  logic [15:0] out;
  logic        out_valid;
  logic        out_ready;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mac_array_acc dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .a         (a),
    .b         (b),
    .c_load    (c_load),
    .c_in      (c_in),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [15:0] av, input logic [15:0] bv,
                        input logic last, input logic cl, input logic [15:0] ci);
    in_valid = v;
    a        = av;
    b        = bv;
    in_last  = last;
    c_load   = cl;
    c_in     = ci;
  endtask

  // Reference dot product: zero-extended activations times signed weights.
  function automatic logic [15:0] dot(input logic [15:0] av, input logic [15:0] bv);
    int s;
    logic [3:0] bs;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      bs = bv[i*4 +: 4];
      s  = s + int'(av[i*4 +: 4]) * int'($signed(bs));
    end
    return s[15:0];
  endfunction

  logic [15:0] st_a [8];
  logic [15:0] st_b [8];
  logic [15:0] ovf_exp;

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    st_a = '{16'h4321, 16'hFFFF, 16'h0000, 16'h1234, 16'hF0F0, 16'h9A5C, 16'h1111, 16'h8E27};
    st_b = '{16'hE2F1, 16'h8888, 16'h7777, 16'h7F81, 16'h7777, 16'h3C9B, 16'h8000, 16'h5AF6};
`ifdef MAC_SAT_EN
    ovf_exp = 16'h7FFF;
`else
    ovf_exp = 16'h81A3;
`endif

    // ---- reset ----
    reset_n   = 1'b0;
    out_ready = 1'b1;
    set_in(1'b0, '0, '0, 1'b0, 1'b0, '0);
    tick;
    tick;
    check("reset_out", out, 16'h0000);
    check("reset_out_valid", {15'b0, out_valid}, 16'h0001 & 16'h0000);
    check("reset_in_ready", {15'b0, in_ready}, 16'h0001);
    reset_n = 1'b1;
    tick;

    // ---- single-beat group with seed: -3 + 10 = 7 ----
    set_in(1'b1, 16'h4321, 16'hE2F1, 1'b1, 1'b1, 16'd10);
    tick;
    set_in(1'b0, '0, '0, 1'b0, 1'b0, '0);
    check("single_latency_not_yet", {15'b0, out_valid}, 16'h0000);
    tick;
    check("single_valid", {15'b0, out_valid}, 16'h0001);
    check("single_out", out, 16'h0007);
    tick;
    check("single_drained", {15'b0, out_valid}, 16'h0000);

    // ---- three-beat group, seeds on later beats ignored: 3*(-480) = -1440 ----
    set_in(1'b1, 16'hFFFF, 16'h8888, 1'b0, 1'b0, 16'd0);
    tick;
    set_in(1'b1, 16'hFFFF, 16'h8888, 1'b0, 1'b1, 16'd999);
    tick;
    set_in(1'b1, 16'hFFFF, 16'h8888, 1'b1, 1'b1, 16'd999);
    tick;
    set_in(1'b0, '0, '0, 1'b0, 1'b0, '0);
    check("group3_no_early_result", {15'b0, out_valid}, 16'h0000);
    tick;
    check("group3_valid", {15'b0, out_valid}, 16'h0001);
    check("group3_out", out, 16'hFA60);
    tick;
    check("group3_one_result", {15'b0, out_valid}, 16'h0000);

    // ---- overflow: 32767 + 420 ----
    set_in(1'b1, 16'hFFFF, 16'h7777, 1'b1, 1'b1, 16'd32767);
    tick;
    set_in(1'b0, '0, '0, 1'b0, 1'b0, '0);
    tick;
    check("overflow_out", out, ovf_exp);
    tick;

    // ---- backpressure: A=4 in out, B=8 held in S1, C=12 offered ----
    out_ready = 1'b0;
    set_in(1'b1, 16'h1111, 16'h1111, 1'b1, 1'b0, '0);
    tick;
    set_in(1'b1, 16'h2222, 16'h1111, 1'b1, 1'b0, '0);
    tick;
    set_in(1'b1, 16'h3333, 16'h1111, 1'b1, 1'b0, '0);
    check("bp_first_out", out, 16'd4);
    check("bp_in_ready_low", {15'b0, in_ready}, 16'h0000);
    tick;
    tick;
    check("bp_out_held", out, 16'd4);
    check("bp_valid_held", {15'b0, out_valid}, 16'h0001);
    check("bp_still_blocked", {15'b0, in_ready}, 16'h0000);
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_release", {15'b0, in_ready}, 16'h0001);
    tick;
    set_in(1'b0, '0, '0, 1'b0, 1'b0, '0);
    check("bp_second_out", out, 16'd8);
    check("bp_second_valid", {15'b0, out_valid}, 16'h0001);
    tick;
    check("bp_third_out", out, 16'd12);
    check("bp_third_valid", {15'b0, out_valid}, 16'h0001);
    tick;
    check("bp_drained", {15'b0, out_valid}, 16'h0000);

    // ---- reset mid-group discards partial sum ----
    set_in(1'b1, 16'hFFFF, 16'h7777, 1'b0, 1'b1, 16'd500);
    tick;
    set_in(1'b1, 16'hFFFF, 16'h7777, 1'b0, 1'b0, '0);
    tick;
    set_in(1'b0, '0, '0, 1'b0, 1'b0, '0);
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    check("midreset_valid", {15'b0, out_valid}, 16'h0000);
    set_in(1'b1, 16'h1111, 16'h1111, 1'b1, 1'b0, '0);
    tick;
    set_in(1'b0, '0, '0, 1'b0, 1'b0, '0);
    check("midreset_no_stale_result", {15'b0, out_valid}, 16'h0000);
    tick;
    check("midreset_out", out, 16'd4);
    tick;

    // ---- streaming: 8 single-beat groups, one result per cycle ----
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) set_in(1'b1, st_a[i], st_b[i], 1'b1, 1'b0, '0);
      else       set_in(1'b0, '0, '0, 1'b0, 1'b0, '0);
      tick;
      if (i >= 1) begin
        check($sformatf("stream_valid_%0d", i - 1), {15'b0, out_valid}, 16'h0001);
        check($sformatf("stream_out_%0d", i - 1), out, dot(st_a[i-1], st_b[i-1]));
      end
    end
    tick;
    check("stream_end", {15'b0, out_valid}, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
